alpha_calc_param: RTL and testbench



---
 rtl/alpha_calc_param.sv | 209 ++++++++++++++++++++
 tb/tb_alpha_calc_param.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_calc_param.sv
// alpha_calc_param: accumulates mean-removed cross-correlation and energy over a block
// and divides them into a saturated fixed-point alpha. Optional macro: ALPHA_CALC_ROUND_EN.
module alpha_calc_param #(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_SIZE_LOG = 8,
  parameter int ALPHA_WIDTH  = 10,
  parameter int ALPHA_FRAC   = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   x_valid,
  output logic                   x_ready,
  input  logic [DATA_WIDTH-1:0]  x_data,
  input  logic                   xhat_valid,
  output logic                   xhat_ready,
  input  logic [DATA_WIDTH-1:0]  xhat_data,
  input  logic                   xhat_last_s,
  input  logic                   xmean_valid,
  output logic                   xmean_ready,
  input  logic [DATA_WIDTH-1:0]  xmean_data,
  input  logic                   xhatmean_valid,
  output logic                   xhatmean_ready,
  input  logic [DATA_WIDTH-1:0]  xhatmean_data,
  output logic                   alpha_valid,
  input  logic                   alpha_ready,
  output logic [ALPHA_WIDTH-1:0] alpha_data
);

  localparam int D_W   = DATA_WIDTH + 1;
  localparam int P_W   = 2 * D_W;
  localparam int ACC_W = P_W + MAX_SIZE_LOG;
`ifdef ALPHA_CALC_ROUND_EN
  localparam int Q_W   = ALPHA_WIDTH + 1;
`else
  localparam int Q_W   = ALPHA_WIDTH;
`endif
  localparam int SH_W    = Q_W - ALPHA_WIDTH + ALPHA_FRAC;
  localparam int R_W     = ACC_W + Q_W + 1;
  localparam int DIV_CYC = ALPHA_WIDTH + 2;
  localparam int CNT_W   = $clog2(DIV_CYC);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYC - 1);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(Q_W);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DIV, S_RND, S_OUT} state_t;
  typedef enum logic [1:0] {R_DIV, R_ZERO, R_SAT} res_t;

  function automatic logic [ALPHA_WIDTH-1:0] sat_alpha(input res_t mode,
                                                       input logic [ALPHA_WIDTH:0] val);
    logic [ALPHA_WIDTH-1:0] r;
    if (mode == R_ZERO)
      r = '0;
    else if (mode == R_SAT || val[ALPHA_WIDTH])
      r = '1;
    else
      r = val[ALPHA_WIDTH-1:0];
    return r;
  endfunction

`ifdef ALPHA_CALC_ROUND_EN
  function automatic logic [ALPHA_WIDTH:0] round_half_up(input logic [Q_W-1:0] q);
    return {1'b0, q[Q_W-1:1]} + {{ALPHA_WIDTH{1'b0}}, q[0]};
  endfunction
`endif

  state_t                  state, state_nx;
  logic [DATA_WIDTH-1:0]   xmean_q, xhatmean_q;
  logic signed [ACC_W-1:0] num_acc;
  logic [ACC_W-1:0]        den_acc;
  logic [MAX_SIZE_LOG-1:0] smp_cnt;
  logic [CNT_W-1:0]        div_cnt;
  logic [R_W-1:0]          rem, dsr;
  logic [Q_W-1:0]          quo;
  res_t                    res_mode;
  logic [ALPHA_WIDTH-1:0]  alpha_q;

  logic                    mean_hs, pair_hs, blk_end, div_done;
  logic signed [D_W-1:0]   dx, dh;
  logic signed [P_W-1:0]   prod_xh, prod_hh;
  logic [R_W-1:0]          num_u, den_u;
  logic                    num_pos, is_sat;

  assign mean_hs  = (state == S_IDLE) & xmean_valid & xhatmean_valid;
  assign pair_hs  = (state == S_ACC) & x_valid & xhat_valid;
  assign blk_end  = pair_hs & (xhat_last_s | (&smp_cnt));
  assign div_done = (state == S_DIV) && (div_cnt == DIV_LAST);

  assign dx      = $signed({1'b0, x_data}) - $signed({1'b0, xmean_q});
  assign dh      = $signed({1'b0, xhat_data}) - $signed({1'b0, xhatmean_q});
  assign prod_xh = dh * dx;
  assign prod_hh = dh * dh;

  assign num_u   = {{(R_W-ACC_W){1'b0}}, num_acc};
  assign den_u   = {{(R_W-ACC_W){1'b0}}, den_acc};
  assign num_pos = ~num_acc[ACC_W-1] & (|num_acc);
  assign is_sat  = (num_u << ALPHA_FRAC) >= (den_u << ALPHA_WIDTH);

  assign alpha_valid = (state == S_OUT);
  assign alpha_data  = alpha_q;

  // Readies are forced low while reset is held so nothing is consumed during reset.
  always_comb begin
    x_ready        = 1'b0;
    xhat_ready     = 1'b0;
    xmean_ready    = 1'b0;
    xhatmean_ready = 1'b0;
    if (!rst) begin
      if (state == S_IDLE) begin
        xmean_ready    = 1'b1;
        xhatmean_ready = 1'b1;
      end
      if (state == S_ACC) begin
        x_ready    = x_valid & xhat_valid;
        xhat_ready = x_valid & xhat_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (mean_hs) state_nx = S_ACC;
      S_ACC:  if (blk_end) state_nx = S_DIV;
      S_DIV: begin
        if (div_done) begin
`ifdef ALPHA_CALC_ROUND_EN
          state_nx = S_RND;
`else
          state_nx = S_OUT;
`endif
        end
      end
      S_RND:  state_nx = S_OUT;
      S_OUT:  if (alpha_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage p0: mean capture and accumulation; p1: fixed-length divide; p2: result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xmean_q    <= '0;
      xhatmean_q <= '0;
      num_acc    <= '0;
      den_acc    <= '0;
      smp_cnt    <= '0;
      div_cnt    <= '0;
      rem        <= '0;
      dsr        <= '0;
      quo        <= '0;
      res_mode   <= R_ZERO;
      alpha_q    <= '0;
    end else begin
      if (mean_hs) begin
        xmean_q    <= xmean_data;
        xhatmean_q <= xhatmean_data;
        num_acc    <= '0;
        den_acc    <= '0;
        smp_cnt    <= '0;
      end
      if (pair_hs) begin
        num_acc <= num_acc + $signed({{(ACC_W-P_W){prod_xh[P_W-1]}}, prod_xh});
        den_acc <= den_acc + {{(ACC_W-P_W){1'b0}}, prod_hh};
        smp_cnt <= smp_cnt + MAX_SIZE_LOG'(1);
      end
      if (blk_end)
        div_cnt <= '0;

      // The divider always runs the full count so latency is data-independent.
      if (state == S_DIV) begin
        div_cnt <= div_cnt + CNT_W'(1);
        if (div_cnt == '0) begin
          rem <= num_u << SH_W;
          dsr <= den_u << (Q_W - 1);
          quo <= '0;
          if (den_acc == '0 || !num_pos)
            res_mode <= R_ZERO;
          else if (is_sat)
            res_mode <= R_SAT;
          else
            res_mode <= R_DIV;
        end else if (div_cnt <= ITER_LAST) begin
          if (rem >= dsr) begin
            rem <= rem - dsr;
            quo <= {quo[Q_W-2:0], 1'b1};
          end else begin
            quo <= {quo[Q_W-2:0], 1'b0};
          end
          dsr <= dsr >> 1;
        end
      end

`ifdef ALPHA_CALC_ROUND_EN
      if (state == S_RND)
        alpha_q <= sat_alpha(res_mode, round_half_up(quo));
`else
      if (div_done)
        alpha_q <= sat_alpha(res_mode, {1'b0, quo});
`endif
    end
  end

endmodule

// File: tb/tb_alpha_calc_param.sv
// Scoreboard bench for alpha_calc_param: directed blocks push expected alpha and the
// edge of the block-ending pair; a monitor checks value, latency and stall behaviour.
module tb_alpha_calc_param;

  localparam int DW  = 16;
  localparam int MSL = 2;
  localparam int AW  = 10;
  localparam int AF  = 9;
`ifdef ALPHA_CALC_ROUND_EN
  localparam int LAT     = AW + 3;
  localparam int RND_EXP = 171;
`else
  localparam int LAT     = AW + 2;
  localparam int RND_EXP = 170;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          x_valid = 1'b0, xhat_valid = 1'b0, xhat_last_s = 1'b0;
  logic          xmean_valid = 1'b0, xhatmean_valid = 1'b0;
  logic [DW-1:0] x_data = '0, xhat_data = '0, xmean_data = '0, xhatmean_data = '0;
  logic          x_ready, xhat_ready, xmean_ready, xhatmean_ready;
  logic          alpha_valid;
  logic          alpha_ready = 1'b1;
  logic [AW-1:0] alpha_data;

  alpha_calc_param #(
    .DATA_WIDTH  (DW),
    .MAX_SIZE_LOG(MSL),
    .ALPHA_WIDTH (AW),
    .ALPHA_FRAC  (AF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .x_valid       (x_valid),
    .x_ready       (x_ready),
    .x_data        (x_data),
    .xhat_valid    (xhat_valid),
    .xhat_ready    (xhat_ready),
    .xhat_data     (xhat_data),
    .xhat_last_s   (xhat_last_s),
    .xmean_valid   (xmean_valid),
    .xmean_ready   (xmean_ready),
    .xmean_data    (xmean_data),
    .xhatmean_valid(xhatmean_valid),
    .xhatmean_ready(xhatmean_ready),
    .xhatmean_data (xhatmean_data),
    .alpha_valid   (alpha_valid),
    .alpha_ready   (alpha_ready),
    .alpha_data    (alpha_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          val;
    int unsigned cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int bx[8];
  int bh[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int v, input int unsigned c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic setp(input int i, input int xv, input int hv);
    bx[i] = xv;
    bh[i] = hv;
  endtask

  task automatic send_means(input int mx, input int mh);
    bit got = 1'b0;
    xmean_data     = 16'(mx);
    xhatmean_data  = 16'(mh);
    xmean_valid    = 1'b1;
    xhatmean_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (xmean_ready && xhatmean_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    xmean_valid    = 1'b0;
    xhatmean_valid = 1'b0;
    check("means_handshake", int'(got), 1);
  endtask

  task automatic send_pair(input int xv, input int hv, input bit last, output int unsigned c);
    bit got = 1'b0;
    int gap = int'($urandom_range(0, 1));
    repeat (gap) begin
      @(posedge clk); #1;
    end
    x_data      = 16'(xv);
    xhat_data   = 16'(hv);
    xhat_last_s = last;
    x_valid     = 1'b1;
    xhat_valid  = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (x_ready && xhat_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    c           = cyc;
    x_valid     = 1'b0;
    xhat_valid  = 1'b0;
    xhat_last_s = 1'b0;
    if (!got) check("pair_handshake", int'(got), 1);
  endtask

  task automatic run_block(input int mx, input int mh, input int n, input int ev, input bit push);
    int unsigned c = 0;
    send_means(mx, mh);
    for (int i = 0; i < n; i++)
      send_pair(bx[i], bh[i], (i == n - 1), c);
    if (push) push_exp(ev, c);
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_pending", int'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: compares every presented alpha against the scoreboard head.
  logic prev_av = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_av <= 1'b0;
    end else begin
      if (alpha_valid) begin
        if (exp_q.size() == 0) begin
          check("alpha_unexpected", int'(alpha_valid), 0);
        end else begin
          e = exp_q[0];
          if (!prev_av) check("alpha_latency", int'(cyc - e.cyc), LAT);
          check("alpha_data", int'(alpha_data), e.val);
          check("ready_in_out", int'({x_ready, xhat_ready, xmean_ready, xhatmean_ready}), 0);
          if (alpha_ready) void'(exp_q.pop_front());
        end
      end
      prev_av <= alpha_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit          got;
    int unsigned c;

    // Reset with all valids high: nothing may be ready or valid.
    x_valid = 1'b1; xhat_valid = 1'b1; xmean_valid = 1'b1; xhatmean_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_alpha_valid", int'(alpha_valid), 0);
    check("rst_alpha_data", int'(alpha_data), 0);
    check("rst_readies", int'({x_ready, xhat_ready, xmean_ready, xhatmean_ready}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    x_valid = 1'b0; xhat_valid = 1'b0; xmean_valid = 1'b0; xhatmean_valid = 1'b0;
    @(negedge clk);
    check("idle_mean_ready", int'({xmean_ready, xhatmean_ready}), 3);
    check("idle_x_ready", int'({x_ready, xhat_ready}), 0);
    @(posedge clk); #1;

    // Identity
    setp(0, 10, 10); setp(1, 20, 20); setp(2, 30, 30); setp(3, 40, 40);
    run_block(25, 25, 4, 512, 1'b1);
    drain();

    // Saturation: dx = 2*dh
    setp(0, 23, 24); setp(1, 27, 26);
    run_block(25, 25, 2, 1023, 1'b1);
    drain();

    // Negative correlation
    setp(0, 27, 24); setp(1, 23, 26);
    run_block(25, 25, 2, 0, 1'b1);
    drain();

    // Zero energy in xhat
    setp(0, 10, 25); setp(1, 30, 25); setp(2, 50, 25);
    run_block(25, 25, 3, 0, 1'b1);
    drain();

    // x constant at its mean
    setp(0, 30, 10); setp(1, 30, 20); setp(2, 30, 30);
    run_block(30, 20, 3, 0, 1'b1);
    drain();

    // Rounding case 512/3
    setp(0, 26, 26); setp(1, 25, 26); setp(2, 25, 26);
    run_block(25, 25, 3, RND_EXP, 1'b1);
    drain();

    // num=1, den=5 -> 102.4
    setp(0, 26, 27); setp(1, 26, 24);
    run_block(25, 25, 2, 102, 1'b1);
    drain();

    // Single-sample block: dh=2, dx=1 -> 0.5
    setp(0, 26, 27);
    run_block(25, 25, 1, 256, 1'b1);
    drain();

    // Forced end after 4 pairs; pairs 5-6 form the next block
    setp(0, 10, 10); setp(1, 20, 20); setp(2, 30, 30); setp(3, 40, 40);
    setp(4, 23, 24); setp(5, 27, 26);
    fork
      begin
        send_means(25, 25);
        send_means(25, 25);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          send_pair(bx[i], bh[i], (i == 5), c);
          if (i == 3) push_exp(512, c);
          if (i == 5) push_exp(1023, c);
        end
      end
    join
    drain();

    // Backpressure: alpha_ready low for 7 cycles with random input valids
    setp(0, 10, 10); setp(1, 20, 20); setp(2, 30, 30); setp(3, 40, 40);
    alpha_ready = 1'b0;
    run_block(25, 25, 4, 512, 1'b1);
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (alpha_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("flow_alpha_seen", int'(got), 1);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      x_valid        = 1'($urandom_range(0, 1));
      xhat_valid     = 1'($urandom_range(0, 1));
      xmean_valid    = 1'($urandom_range(0, 1));
      xhatmean_valid = 1'($urandom_range(0, 1));
      x_data         = 16'($urandom);
      xhat_data      = 16'($urandom);
      @(negedge clk);
      check("flow_valid_held", int'(alpha_valid), 1);
      check("flow_no_accept", int'({x_ready, xhat_ready, xmean_ready, xhatmean_ready}), 0);
    end
    @(posedge clk); #1;
    x_valid = 1'b0; xhat_valid = 1'b0; xmean_valid = 1'b0; xhatmean_valid = 1'b0;
    alpha_ready = 1'b1;
    drain();

    // Reset mid-division: block discarded, no alpha for it
    setp(0, 23, 24); setp(1, 27, 26);
    run_block(25, 25, 2, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    x_valid = 1'b1; xhat_valid = 1'b1; xmean_valid = 1'b1; xhatmean_valid = 1'b1;
    @(negedge clk);
    check("midrst_alpha_valid", int'(alpha_valid), 0);
    check("midrst_alpha_data", int'(alpha_data), 0);
    check("midrst_readies", int'({x_ready, xhat_ready, xmean_ready, xhatmean_ready}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    x_valid = 1'b0; xhat_valid = 1'b0; xmean_valid = 1'b0; xhatmean_valid = 1'b0;
    @(negedge clk);
    check("midrst_idle", int'({xmean_ready, xhatmean_ready}), 3);
    repeat (20) @(posedge clk);
    #1;
    setp(0, 10, 10); setp(1, 20, 20); setp(2, 30, 30); setp(3, 40, 40);
    run_block(25, 25, 4, 512, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
